bfly_r2_pipe: RTL
=================

BFLY_R2_PIPE -- requirements
Module: bfly_r2_pipe

Interface
REQ-001 Parameter DW, default 16, signed width of each real/imag component of data inputs and outputs.
REQ-002 Parameter TW, default 16, signed width of each twiddle component, format Q1.(TW-1).
REQ-003 clk  input  1  single clock; all registers rise on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  input triple (a, b, w) valid.
REQ-006 in_ready  output  1  block accepts input this cycle.
REQ-007 a  input  2*DW  butterfly top operand, {imag, real}.
REQ-008 b  input  2*DW  butterfly bottom operand, {imag, real}.
REQ-009 w  input  2*TW  twiddle factor, {imag, real}.
REQ-010 scale  input  1  1 = divide both outputs by 2; sampled with the input triple.
REQ-011 out_valid  output  1  x0/x1 valid.
REQ-012 out_ready  input  1  downstream accepts output.
REQ-013 x0  output  2*DW  a + b*w, {imag, real}.
REQ-014 x1  output  2*DW  a - b*w, {imag, real}.
REQ-015 ovf  output  1  sticky overflow flag.
REQ-016 ovf_clr  input  1  synchronous clear of ovf.

Function
REQ-017 Transfer occurs when in_valid && in_ready; output accepted when out_valid && out_ready.
REQ-018 Pipeline SHALL be 4 stages: S1 register a, b, w, scale; S2 four signed products br*wr, bi*wi, br*wi, bi*wr; S3 t = b*w real/imag sums, rounded; S4 butterfly add/sub, scale, limit, register outputs.
REQ-019 Latency SHALL be exactly 4 cycles from accepted input to out_valid with no stall; throughput one result per cycle.
REQ-020 Operand a and scale SHALL be delayed alongside the product path so that x0/x1 always combine a and b*w from the same input transfer.
REQ-021 Stall: advance = out_ready || !out_valid; in_ready = advance; when advance is 0 every pipeline register, including valid bits, SHALL hold.
REQ-022 x0/x1 SHALL remain stable while out_valid && !out_ready.
REQ-023 Product sums at full width (DW+TW+1 bits); t = (sum + 2^(TW-2)) >>> (TW-1), arithmetic shift (round half up), kept at DW+1 bits.
REQ-024 Butterfly: s0 = a + t, s1 = a - t at DW+2 bits; if scale, s = s >>> 1 (truncate toward minus infinity).
REQ-025 Each of the four output components SHALL be limited to DW bits per REQ-031.
REQ-026 ovf SHALL set in the cycle any S4 component exceeds the DW range on an advancing valid beat; ovf_clr clears it; simultaneous set and clear -> ovf = 1.
REQ-027 Invalid (bubble) beats SHALL never affect ovf.

Reset
REQ-028 While rst_n = 0: all valid bits 0, out_valid = 0, x0 = 0, x1 = 0, ovf = 0; in_ready = 1 from the first cycle after release.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight beats; no out_valid until 4 cycles after a new accepted input.
REQ-030 Data-path registers other than outputs need no reset.

Configuration
REQ-031 Macro BFLY_SAT_EN: defined -> out-of-range components saturate to +2^(DW-1)-1 / -2^(DW-1) and ovf operates per REQ-026; undefined -> components wrap (two's-complement truncation to DW bits) and ovf is tied 0.

Verification (DW=16, TW=16)
REQ-032 a=(re 1000, im 0), b=(2000,0), w=(0x4000,0), scale=0 -> after 4 cycles x0=(2000,0), x1=(0,0).
REQ-033 a=(0,0), b=(100,200), w=(re 0, im 0x8000), scale=0 -> x0=(200,-100), x1=(-200,100).
REQ-034 a=(30000,0), b=(30000,0), w=(0x4000,0), scale=0 -> with BFLY_SAT_EN x0.re=32767, x1.re=15000, ovf=1; without it x0.re=-20536, ovf=0; scale=1 -> x0.re=22500, x1.re=7500, ovf unchanged.
REQ-035 8 back-to-back inputs, out_ready low for cycles 6-9 -> in_ready low those cycles, outputs held, all 8 results emitted in order, none lost or duplicated.
REQ-036 rst_n pulsed low with 3 beats in flight -> out_valid=0, ovf=0, no stale result emerges; next input returns correct result after 4 cycles.

Source files
------------

// File: rtl/bfly_r2_pipe_if.sv
// rtl/bfly_r2_pipe_if.sv - input/output stream bundle for the radix-2 butterfly pipeline
// master drives operands and out_ready; slave is the butterfly itself.
interface bfly_r2_pipe_if #(
  parameter int DW = 16,
  parameter int TW = 16
);
  logic            in_valid;
  logic            in_ready;
  logic [2*DW-1:0] a;
  logic [2*DW-1:0] b;
  logic [2*TW-1:0] w;
  logic            scale;
  logic            out_valid;
  logic            out_ready;
  logic [2*DW-1:0] x0;
  logic [2*DW-1:0] x1;

  modport master (
    output in_valid, a, b, w, scale, out_ready,
    input  in_ready, out_valid, x0, x1
  );

  modport slave (
    input  in_valid, a, b, w, scale, out_ready,
    output in_ready, out_valid, x0, x1
  );
endinterface

// File: rtl/bfly_r2_pipe.sv
// rtl/bfly_r2_pipe.sv - 4-stage radix-2 butterfly x0/x1 = a +/- b*w with stall and optional halving
// BFLY_SAT_EN: defined -> out-of-range outputs saturate and sticky ovf is live; undefined -> wrap, ovf tied 0
module bfly_r2_pipe #(
  parameter int DW = 16,
  parameter int TW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  bfly_r2_pipe_if.slave bus,
  output logic          ovf,
  input  logic          ovf_clr
);
  localparam int PW = DW + TW;
  localparam int SW = DW + TW + 1;
  localparam int TD = DW + 1;
  localparam int BW = DW + 2;
  localparam logic signed [SW-1:0] RND = SW'(1) <<< (TW - 2);

  logic advance;
  logic v1, v2, v3, v4;

  assign advance       = bus.out_ready || !v4;
  assign bus.in_ready  = advance;
  assign bus.out_valid = v4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else if (advance) begin
      v1 <= bus.in_valid;
      v2 <= v1;
      v3 <= v2;
    end
  end

  logic signed [DW-1:0] a1_re, a1_im, b1_re, b1_im;
  logic signed [TW-1:0] w1_re, w1_im;
  logic                 sc1;
  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [DW-1:0] a2_re, a2_im, a3_re, a3_im;
  logic                 sc2, sc3;
  logic signed [TD-1:0] t3_re, t3_im;
  logic signed [SW-1:0] sum_re, sum_im;

  assign sum_re = SW'(p_rr) - SW'(p_ii);
  assign sum_im = SW'(p_ri) + SW'(p_ir);

  // a and scale ride alongside the product path so each result pairs one transfer's operands
  always_ff @(posedge clk) begin
    if (advance) begin
      a1_re <= bus.a[DW-1:0];
      a1_im <= bus.a[2*DW-1:DW];
      b1_re <= bus.b[DW-1:0];
      b1_im <= bus.b[2*DW-1:DW];
      w1_re <= bus.w[TW-1:0];
      w1_im <= bus.w[2*TW-1:TW];
      sc1   <= bus.scale;
      p_rr  <= PW'(b1_re) * PW'(w1_re);
      p_ii  <= PW'(b1_im) * PW'(w1_im);
      p_ri  <= PW'(b1_re) * PW'(w1_im);
      p_ir  <= PW'(b1_im) * PW'(w1_re);
      a2_re <= a1_re;
      a2_im <= a1_im;
      sc2   <= sc1;
      t3_re <= TD'((sum_re + RND) >>> (TW - 1));
      t3_im <= TD'((sum_im + RND) >>> (TW - 1));
      a3_re <= a2_re;
      a3_im <= a2_im;
      sc3   <= sc2;
    end
  end

  function automatic logic signed [BW-1:0] halve(input logic signed [BW-1:0] s, input logic sc);
    return sc ? (s >>> 1) : s;
  endfunction

  function automatic logic fits(input logic signed [BW-1:0] s);
    return (s[BW-1:DW-1] == '0) || (s[BW-1:DW-1] == '1);
  endfunction

  function automatic logic [DW-1:0] lim(input logic signed [BW-1:0] s);
`ifdef BFLY_SAT_EN
    if (fits(s)) return s[DW-1:0];
    return s[BW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
`else
    return s[DW-1:0];
`endif
  endfunction

  logic signed [BW-1:0] s0_re, s0_im, s1_re, s1_im;
  logic                 s4_ovf;

  assign s0_re  = halve(BW'(a3_re) + BW'(t3_re), sc3);
  assign s0_im  = halve(BW'(a3_im) + BW'(t3_im), sc3);
  assign s1_re  = halve(BW'(a3_re) - BW'(t3_re), sc3);
  assign s1_im  = halve(BW'(a3_im) - BW'(t3_im), sc3);
  assign s4_ovf = !(fits(s0_re) && fits(s0_im) && fits(s1_re) && fits(s1_im));

  logic [2*DW-1:0] x0_q, x1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v4   <= 1'b0;
      x0_q <= '0;
      x1_q <= '0;
    end else if (advance) begin
      v4 <= v3;
      if (v3) begin
        x0_q <= {lim(s0_im), lim(s0_re)};
        x1_q <= {lim(s1_im), lim(s1_re)};
      end
    end
  end

  assign bus.x0 = x0_q;
  assign bus.x1 = x1_q;

`ifdef BFLY_SAT_EN
  // set wins over a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      ovf <= 1'b0;
    else if (advance && v3 && s4_ovf) ovf <= 1'b1;
    else if (ovf_clr)                ovf <= 1'b0;
  end
`else
  logic unused_wrap;
  assign unused_wrap = ^{s4_ovf, ovf_clr};
  assign ovf = 1'b0;
`endif
endmodule
